// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Small instruction buffer plus run controller that feeds 32-bit instruction
// words to a datapath. Words are appended to the buffer while the sequencer is
// idle. A run then issues them in order, either free-running (one word per
// cycle) or one word per step pulse. A halt word (opcode field all ones) ends
// the run without being issued. An abort ends the run without a done pulse.
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   reset        : asynchronous active-low reset
//   load_valid   : load request qualifying load_data
//   load_data    : instruction word appended to the buffer on a handshake
//   load_ready   : buffer accepts a word this cycle
//   clear        : empty the buffer (IDLE only, start has priority)
//   start        : begin a run (IDLE only)
//   step_mode    : single-step select, latched when start is accepted
//   step         : advance one instruction while waiting in single-step mode
//   abort        : terminate a run in progress (RUN or WAIT only)
//   instruction  : word driven to the datapath, NOP (zero) when not issuing
//   issue_valid  : instruction is live this cycle
//   pc           : current buffer read index
//   count        : number of loaded words, 0..DEPTH
//   issued       : instructions issued in the current or last run
//   busy         : a run is in progress (RUN or WAIT)
//   done         : one-cycle pulse when a run completes normally
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [31:0]   load_data,
    output logic          load_ready,
    input  logic          clear,
    input  logic          start,
    input  logic          step_mode,
    input  logic          step,
    input  logic          abort,
    output logic [31:0]   instruction,
    output logic          issue_valid,
    output logic [AW-1:0] pc,
    output logic [AW:0]   count,
    output logic [AW:0]   issued,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PC_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [31:0]   NOP     = 32'h0000_0000;

    // Halt words are recognised by their opcode field alone.
    function automatic logic is_halt(input logic [5:0] opcode);
        return (opcode == 6'b111111);
    endfunction

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   count_q, count_d;
    logic [AW:0]   issued_q, issued_d;
    logic          step_mode_q, step_mode_d;

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   cur_word_s;
    logic          cur_halt_s;
    logic          last_s;
    logic          load_ready_s;
    logic          load_fire_s;

    assign cur_word_s   = mem_q[pc_q];
    assign cur_halt_s   = is_halt(cur_word_s[31:26]);
    // count is never zero in RUN, so count-1 cannot underflow there.
    assign last_s       = ({1'b0, pc_q} == (count_q - CNT_ONE));
    // start and clear both block loads so a command cycle never also appends.
    assign load_ready_s = (state_q == S_IDLE) && (count_q < DEPTH_C) && !start && !clear;
    assign load_fire_s  = load_valid && load_ready_s;

    // Next-state and datapath-register update logic for the run controller.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        count_d     = count_q;
        issued_d    = issued_q;
        step_mode_d = step_mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d        = '0;
                    issued_d    = '0;
                    step_mode_d = step_mode;
                    if (count_q == '0) begin
                        state_d = S_DONE;
                    end else if (step_mode) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (clear) begin
                    count_d = '0;
                end else if (load_fire_s) begin
                    count_d = count_q + CNT_ONE;
                end else begin
                    count_d = count_q;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cur_halt_s) begin
                    // Halt word is never issued; pc keeps pointing at it.
                    state_d = S_DONE;
                end else if (last_s) begin
                    issued_d = issued_q + CNT_ONE;
                    state_d  = S_DONE;
                end else begin
                    issued_d = issued_q + CNT_ONE;
                    pc_d     = pc_q + PC_ONE;
                    if (step_mode_q) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (step) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Controller state registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            step_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            step_mode_q <= step_mode_d;
        end
    end

    // Instruction buffer storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (load_fire_s) begin
            mem_q[count_q[AW-1:0]] <= load_data;
        end
    end

    // Issue path: the live word is suppressed on a halt word or an abort cycle.
    always_comb begin
        instruction = NOP;
        issue_valid = 1'b0;
        if ((state_q == S_RUN) && !abort && !cur_halt_s) begin
            instruction = cur_word_s;
            issue_valid = 1'b1;
        end else begin
            instruction = NOP;
            issue_valid = 1'b0;
        end
    end

    assign load_ready = load_ready_s;
    assign pc         = pc_q;
    assign count      = count_q;
    assign issued     = issued_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_WAIT);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_valid = 1'b0;
    logic [31:0]   load_data = 32'h0;
    logic          load_ready;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   instruction;
    logic          issue_valid;
    logic [AW-1:0] pc;
    logic [AW:0]   count;
    logic [AW:0]   issued;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .clear(clear), .start(start), .step_mode(step_mode), .step(step), .abort(abort),
        .instruction(instruction), .issue_valid(issue_valid),
        .pc(pc), .count(count), .issued(issued), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Stimulus helpers: inputs change on the falling edge only.
    task automatic load_word(input logic [31:0] w);
        load_valid = 1'b1; load_data = w;
        @(negedge clk);
        load_valid = 1'b0; load_data = 32'h0;
    endtask

    task automatic do_clear;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (pc !== 4'd0) begin n_err++; $display("FAIL reset_pc: got %0d expected 0", pc); end
        n_cmp++; if (issued !== 5'd0) begin n_err++; $display("FAIL reset_issued: got %0d expected 0", issued); end
        n_cmp++; if (issue_valid !== 1'b0 || instruction !== 32'h0) begin n_err++; $display("FAIL reset_issue: got %0b/%h expected 0/00000000", issue_valid, instruction); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (load_ready !== 1'b1) begin n_err++; $display("FAIL idle_load_ready: got %0b expected 1", load_ready); end
    endtask

    task automatic test_run;
        logic [31:0] w [3];
        w[0] = 32'h2001000A; w[1] = 32'h20020014; w[2] = 32'h00221820;
        for (int i = 0; i < 3; i++) load_word(w[i]);
        n_cmp++; if (count !== 5'd3) begin n_err++; $display("FAIL run_count: got %0d expected 3", count); end
        start = 1'b1; step_mode = 1'b0;
        #1;
        n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL run_ready_at_start: got %0b expected 0", load_ready); end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (instruction !== w[i] || issue_valid !== 1'b1) begin n_err++; $display("FAIL run_issue%0d: got %h/%0b expected %h/1", i, instruction, issue_valid, w[i]); end
            n_cmp++; if (busy !== 1'b1 || load_ready !== 1'b0) begin n_err++; $display("FAIL run_busy%0d: got busy=%0b ready=%0b expected 1/0", i, busy, load_ready); end
            @(negedge clk);
        end
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL run_done: got done=%0b busy=%0b expected 1/0", done, busy); end
        n_cmp++; if (issued !== 5'd3 || pc !== 4'd2) begin n_err++; $display("FAIL run_final: got issued=%0d pc=%0d expected 3/2", issued, pc); end
        n_cmp++; if (issue_valid !== 1'b0 || instruction !== 32'h0) begin n_err++; $display("FAIL run_done_nop: got %0b/%h expected 0/00000000", issue_valid, instruction); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || issued !== 5'd3 || pc !== 4'd2) begin n_err++; $display("FAIL run_after_done: got done=%0b issued=%0d pc=%0d expected 0/3/2", done, issued, pc); end
    endtask

    task automatic test_halt;
        do_clear;
        n_cmp++; if (count !== 5'd0) begin n_err++; $display("FAIL halt_clear: got %0d expected 0", count); end
        load_word(32'h2001000A); load_word(32'hFC000000); load_word(32'h20020014);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        n_cmp++; if (instruction !== 32'h2001000A || issue_valid !== 1'b1) begin n_err++; $display("FAIL halt_first: got %h/%0b expected 2001000a/1", instruction, issue_valid); end
        @(negedge clk);
        #1;
        n_cmp++; if (instruction !== 32'h0 || issue_valid !== 1'b0) begin n_err++; $display("FAIL halt_suppress: got %h/%0b expected 00000000/0", instruction, issue_valid); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b1 || issued !== 5'd1 || pc !== 4'd1) begin n_err++; $display("FAIL halt_done: got done=%0b issued=%0d pc=%0d expected 1/1/1", done, issued, pc); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL halt_idle: got done=%0b busy=%0b expected 0/0", done, busy); end
    endtask

    task automatic test_step;
        logic [31:0] w [2];
        w[0] = 32'h12345678; w[1] = 32'h0ABCDEF0;
        do_clear;
        load_word(w[0]); load_word(w[1]);
        start = 1'b1; step_mode = 1'b1;
        @(negedge clk);
        start = 1'b0; step_mode = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1 || issue_valid !== 1'b0 || instruction !== 32'h0) begin n_err++; $display("FAIL step_wait: got busy=%0b v=%0b i=%h expected 1/0/0", busy, issue_valid, instruction); end
        for (int k = 0; k < 2; k++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            #1;
            n_cmp++; if (instruction !== w[k] || issue_valid !== 1'b1) begin n_err++; $display("FAIL step_issue%0d: got %h/%0b expected %h/1", k, instruction, issue_valid, w[k]); end
            @(negedge clk);
            if (k == 0) begin
                for (int c = 0; c < 4; c++) begin
                    #1;
                    n_cmp++; if (instruction !== 32'h0 || issue_valid !== 1'b0 || issued !== 5'd1) begin n_err++; $display("FAIL step_gap%0d: got %h/%0b issued=%0d expected 0/0/1", c, instruction, issue_valid, issued); end
                    if (c < 3) @(negedge clk);
                end
            end
        end
        n_cmp++; if (done !== 1'b1 || issued !== 5'd2 || pc !== 4'd1) begin n_err++; $display("FAIL step_done: got done=%0b issued=%0d pc=%0d expected 1/2/1", done, issued, pc); end
        @(negedge clk);
    endtask

    task automatic test_full;
        do_clear;
        for (int i = 0; i < DEPTH; i++) load_word(32'h0000_1000 + 32'(i));
        n_cmp++; if (count !== 5'd16 || load_ready !== 1'b0) begin n_err++; $display("FAIL full_count: got count=%0d ready=%0b expected 16/0", count, load_ready); end
        load_word(32'hDEADBEEF);
        n_cmp++; if (count !== 5'd16) begin n_err++; $display("FAIL full_17th: got %0d expected 16", count); end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            n_cmp++; if (instruction !== (32'h0000_1000 + 32'(i)) || issue_valid !== 1'b1) begin n_err++; $display("FAIL full_issue%0d: got %h/%0b expected %h/1", i, instruction, issue_valid, 32'h0000_1000 + 32'(i)); end
            @(negedge clk);
        end
        n_cmp++; if (done !== 1'b1 || issued !== 5'd16 || pc !== 4'd15 || count !== 5'd16) begin n_err++; $display("FAIL full_done: got done=%0b issued=%0d pc=%0d count=%0d expected 1/16/15/16", done, issued, pc, count); end
        @(negedge clk);
    endtask

    task automatic test_abort;
        logic [31:0] w [4];
        w[0] = 32'h00000011; w[1] = 32'h00000022; w[2] = 32'h00000033; w[3] = 32'h00000044;
        do_clear;
        for (int i = 0; i < 4; i++) load_word(w[i]);
        start = 1'b1; clear = 1'b1; load_valid = 1'b1; load_data = 32'h11111111;
        #1;
        n_cmp++; if (load_ready !== 1'b0) begin n_err++; $display("FAIL abort_cmd_ready: got %0b expected 0", load_ready); end
        @(negedge clk);
        start = 1'b0; clear = 1'b0; load_valid = 1'b0; load_data = 32'h0;
        #1;
        n_cmp++; if (count !== 5'd4 || busy !== 1'b1) begin n_err++; $display("FAIL abort_start_prio: got count=%0d busy=%0b expected 4/1", count, busy); end
        n_cmp++; if (instruction !== w[0] || issue_valid !== 1'b1) begin n_err++; $display("FAIL abort_first: got %h/%0b expected %h/1", instruction, issue_valid, w[0]); end
        @(negedge clk);
        abort = 1'b1;
        #1;
        n_cmp++; if (instruction !== 32'h0 || issue_valid !== 1'b0) begin n_err++; $display("FAIL abort_suppress: got %h/%0b expected 00000000/0", instruction, issue_valid); end
        @(negedge clk);
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || issued !== 5'd1) begin n_err++; $display("FAIL abort_idle: got busy=%0b done=%0b issued=%0d expected 0/0/1", busy, done, issued); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %0b expected 0", done); end
        do_clear;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (done !== 1'b1 || issued !== 5'd0 || busy !== 1'b0) begin n_err++; $display("FAIL empty_done: got done=%0b issued=%0d busy=%0b expected 1/0/0", done, issued, busy); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL empty_done_len: got %0b expected 0", done); end
    endtask

    task automatic test_reset_midrun;
        do_clear;
        load_word(32'h01010101); load_word(32'h02020202); load_word(32'h03030303);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || issue_valid !== 1'b0 || instruction !== 32'h0) begin n_err++; $display("FAIL midrst_ctrl: got busy=%0b done=%0b v=%0b i=%h expected 0/0/0/0", busy, done, issue_valid, instruction); end
        n_cmp++; if (pc !== 4'd0 || count !== 5'd0 || issued !== 5'd0) begin n_err++; $display("FAIL midrst_regs: got pc=%0d count=%0d issued=%0d expected 0/0/0", pc, count, issued); end
        #1;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || load_ready !== 1'b1) begin n_err++; $display("FAIL midrst_after: got busy=%0b done=%0b ready=%0b expected 0/0/1", busy, done, load_ready); end
    endtask

    initial begin
        test_reset;
        test_run;
        test_halt;
        test_step;
        test_full;
        test_abort;
        test_reset_midrun;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, as the number of 32-bit instruction buffer entries (power of two).
REQ-002 The block SHALL have parameter AW, default 4, as the buffer address width (log2 DEPTH).
REQ-003 The block SHALL have port clk  input  1  as the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port reset  input  1  as the asynchronous, active-low reset.
REQ-005 The block SHALL have port load_valid  input  1  as the load request qualifying load_data.
REQ-006 The block SHALL have port load_data  input  32  as the instruction word to append to the buffer.
REQ-007 The block SHALL have port load_ready  output  1  as "buffer accepts a word this cycle".
REQ-008 The block SHALL have port clear  input  1  as the buffer-empty command, honoured in IDLE only.
REQ-009 The block SHALL have port start  input  1  as the run-program command, honoured in IDLE only.
REQ-010 The block SHALL have port step_mode  input  1  as the single-step mode select, sampled at start.
REQ-011 The block SHALL have port step  input  1  as the single-step advance in WAIT.
REQ-012 The block SHALL have port abort  input  1  as the run-terminate command.
REQ-013 The block SHALL have port instruction  output  32  as the word driven to the datapath instruction input.
REQ-014 The block SHALL have port issue_valid  output  1  as "instruction is live this cycle".
REQ-015 The block SHALL have port pc  output  AW  as the current buffer read index.
REQ-016 The block SHALL have port count  output  AW+1  as the number of loaded words, 0..DEPTH.
REQ-017 The block SHALL have port issued  output  AW+1  as the number of instructions issued in the current or last run.
REQ-018 The block SHALL have ports busy  output  1  and done  output  1, meaning a run is in progress and a one-cycle run-complete pulse.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, WAIT and DONE, and busy SHALL be 1 in RUN or WAIT.
REQ-020 load_ready SHALL equal (state==IDLE && count<DEPTH && !start && !clear).
REQ-021 A load handshake (load_valid && load_ready) SHALL write buf[count] and increment count at the same edge.
REQ-022 clear in IDLE SHALL set count=0 at the next edge, and start SHALL take priority over clear if both are high.
REQ-023 On start in IDLE, pc and issued SHALL be set to 0 and the FSM SHALL go to DONE if count==0, else to WAIT if step_mode==1, else to RUN.
REQ-024 The halt word SHALL be any instruction with bits[31:26]==6'b111111.
REQ-025 In RUN: instruction=buf[pc] and issue_valid=1, except that both SHALL be 0 when buf[pc] is a halt word or abort==1.
REQ-026 In every state other than RUN, instruction SHALL be 32'h00000000 (NOP) and issue_valid SHALL be 0.
REQ-027 At a RUN edge with no abort and a halt word: go to DONE, with pc and issued unchanged.
REQ-028 At a RUN edge with no abort, no halt word and pc==count-1: issued++, then go to DONE.
REQ-029 At any other RUN edge with no abort: issued++ and pc++, then go to WAIT if step mode was latched, else stay in RUN.
REQ-030 In WAIT, step==1 SHALL move the FSM to RUN at the next edge, and each step SHALL produce exactly one issued instruction.
REQ-031 abort in RUN or WAIT SHALL return the FSM to IDLE at the next edge without asserting done; abort in any other state SHALL be ignored.
REQ-032 DONE SHALL last exactly one cycle with done=1, then go to IDLE; pc, issued and the buffer contents SHALL be retained.
REQ-033 Loads SHALL be refused while busy (load_ready=0), and the buffer contents SHALL never change during a run.
REQ-034 Latency SHALL be: start accepted at edge N puts the first instruction on the outputs in the cycle after edge N (non-step mode).

Reset
REQ-035 reset low SHALL immediately force state=IDLE, pc=0, count=0, issued=0, done=0, busy=0, issue_valid=0 and instruction=0; buffer contents SHALL be don't-care.
REQ-036 reset asserted mid-run SHALL abandon the run with no done pulse; the block SHALL leave reset on the first edge after reset goes high.

Verification
REQ-037 Load 0x2001000A, 0x20020014, 0x00221820, then start (step_mode=0) -> instruction shows those 3 words on 3 consecutive cycles with issue_valid=1, then done for 1 cycle; final issued=3 and pc=2.
REQ-038 Load 0x2001000A, 0xFC000000, 0x20020014, then start -> exactly 1 instruction issued, halt word never driven, done pulses, issued=1 and pc=1.
REQ-039 Load 2 words, start with step_mode=1, pulse step twice spaced 5 cycles apart -> each issue occurs one cycle after its step, instruction=0 between steps, done follows the 2nd issue.
REQ-040 Attempt 17 load handshakes with DEPTH=16 -> count=16 and load_ready=0 after the 16th; the 17th word is not stored; start, clear and load in the same cycle -> the run starts and count is unchanged.
REQ-041 Assert abort in the 2nd RUN cycle of a 4-word run -> issue_valid=0 that cycle, IDLE next cycle, no done, issued=1; start on an empty buffer -> done 1 cycle later with issued=0.
REQ-042 Drive reset low mid-run for less than one clock period -> all outputs go to their reset values immediately, without waiting for a clock edge.
